multicycle_controller: RTL

//  Main control FSM of the multicycle MIPS core. Sequences fetch/decode/execute/memory/writeback

---
 rtl/multicycle_pkg.sv | 58 +++++
 rtl/mult_stall_counter.sv | 34 +++
 rtl/multicycle_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// Shared constants for the multicycle MIPS control FSM: state encoding, opcodes and ALU op codes.
package multicycle_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE   = 4'd0;
    localparam logic [STATE_W-1:0] ST_FETCH  = 4'd1;
    localparam logic [STATE_W-1:0] ST_DECODE = 4'd2;
    localparam logic [STATE_W-1:0] ST_MEMADR = 4'd3;
    localparam logic [STATE_W-1:0] ST_MEMRD  = 4'd4;
    localparam logic [STATE_W-1:0] ST_MEMWB  = 4'd5;
    localparam logic [STATE_W-1:0] ST_MEMWR  = 4'd6;
    localparam logic [STATE_W-1:0] ST_EXEC   = 4'd7;
    localparam logic [STATE_W-1:0] ST_ALUWB  = 4'd8;
    localparam logic [STATE_W-1:0] ST_BRANCH = 4'd9;
    localparam logic [STATE_W-1:0] ST_ADDIEX = 4'd10;
    localparam logic [STATE_W-1:0] ST_ADDIWB = 4'd11;
    localparam logic [STATE_W-1:0] ST_JUMP   = 4'd12;

    typedef enum logic [STATE_W-1:0] {
        StIdle   = ST_IDLE,
        StFetch  = ST_FETCH,
        StDecode = ST_DECODE,
        StMemAdr = ST_MEMADR,
        StMemRd  = ST_MEMRD,
        StMemWb  = ST_MEMWB,
        StMemWr  = ST_MEMWR,
        StExec   = ST_EXEC,
        StAluWb  = ST_ALUWB,
        StBranch = ST_BRANCH,
        StAddiEx = ST_ADDIEX,
        StAddiWb = ST_ADDIWB,
        StJump   = ST_JUMP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_MULT = 6'b011000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

endpackage

// File: rtl/mult_stall_counter.sv
// Down-counter that holds EXEC for a multi-cycle multiply; done is high when the count is zero.
module mult_stall_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core. Optional retired-instruction counter is built
// when PERF_CNT_EN is defined.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
`ifdef PERF_CNT_EN
    output logic [31:0] instr_retired,
`endif
    output logic        illegal_op
);

    state_e state_q, state_d;

    logic is_mult;
    logic mult_load;
    logic mult_dec;
    logic mult_done;

    assign is_mult = (funct == FUNCT_MULT);

    // Counter is loaded on the DECODE->EXEC edge so the first EXEC cycle already sees MULT_CYCLES-1.
    assign mult_load = (state_q == StDecode) && (opcode == OP_RTYPE) && is_mult;
    assign mult_dec  = (state_q == StExec) && is_mult && !mult_done;

    mult_stall_counter #(
        .WIDTH (4)
    ) u_mult_stall_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (mult_load),
        .dec      (mult_dec),
        .load_val (4'(MULT_CYCLES - 1)),
        .done     (mult_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        illegal_op    = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // PC and IR load only in the completing cycle so a stall cannot double-advance PC.
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = SRCB_IMM2;
                case (opcode)
                    OP_RTYPE:     state_d = StExec;
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d = StFetch;
                end
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                if (!(is_mult && !mult_done)) begin
                    state_d = StAluWb;
                end
            end
            StAluWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_src        = PCSRC_OUT;
                pc_write_cond = 1'b1;
                state_d       = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef PERF_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic        retire;

    // Only completion states count; illegal ops re-enter FETCH from DECODE and are skipped.
    always_comb begin
        retire = 1'b0;
        if (state_d == StFetch) begin
            case (state_q)
                StMemWb, StMemWr, StAluWb, StBranch, StAddiWb, StJump: retire = 1'b1;
                default: retire = 1'b0;
            endcase
        end
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign instr_retired = retired_q;
`endif

endmodule
